// File: rtl/pwm_pkg.sv
// Shared definitions for the breathing PWM sequencer: state encoding and
// width helpers used to size the duty and pacing counters.
package pwm_pkg;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_UP      = 3'd1;
  localparam logic [2:0] S_HOLD_HI = 3'd2;
  localparam logic [2:0] S_DOWN    = 3'd3;
  localparam logic [2:0] S_HOLD_LO = 3'd4;

  typedef enum logic [2:0] {
    IDLE    = S_IDLE,
    UP      = S_UP,
    HOLD_HI = S_HOLD_HI,
    DOWN    = S_DOWN,
    HOLD_LO = S_HOLD_LO
  } state_t;

  // Duty must represent 0..PERIOD inclusive.
  function automatic int duty_w(input int period);
    return $clog2(period + 1);
  endfunction

  // Counter holding 0..n-1, at least one bit wide.
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pwm_gen_core.sv
// Period counter plus registered duty compare; run=0 parks the counter at 0
// and forces the output low, so a dropped enable abandons the period at once.
module pwm_gen_core #(
  parameter int PERIOD = 100,
  parameter int DUTY_W = 7
)(
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              run,
  input  logic [DUTY_W-1:0] duty,
  output logic              o_pwm,
  output logic              period_end
);

  logic [DUTY_W-1:0] r_cnt;
  logic              r_pwm;
  logic              w_wrap;

  assign w_wrap     = (r_cnt == DUTY_W'(PERIOD - 1));
  assign period_end = run & w_wrap;
  assign o_pwm      = r_pwm;

  // duty==PERIOD keeps cnt<duty true on every count, so no dip at the wrap.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_cnt <= '0;
      r_pwm <= 1'b0;
    end else if (!run) begin
      r_cnt <= '0;
      r_pwm <= 1'b0;
    end else begin
      r_cnt <= w_wrap ? '0 : r_cnt + 1'b1;
      r_pwm <= (r_cnt < duty);
    end
  end

endmodule

// File: rtl/pwm_breath_ctrl.sv
// Breathing-profile sequencer: ramps the duty of a PWM core up, holds, ramps
// down, holds, and repeats; all duty/state changes land on period boundaries.
module pwm_breath_ctrl
  import pwm_pkg::*;
#(
  parameter  int PERIOD           = 100,
  parameter  int STEP             = 1,
  parameter  int PERIODS_PER_STEP = 2,
  parameter  int HOLD_PERIODS     = 4,
  localparam int DUTY_W           = duty_w(PERIOD)
)(
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              i_en,
  output logic              o_pwm,
  output logic [DUTY_W-1:0] o_duty,
  output logic [2:0]        o_state,
  output logic              o_breath_done
);

  localparam int STEP_CW = cnt_w(PERIODS_PER_STEP);
  localparam int HOLD_CW = cnt_w(HOLD_PERIODS);

  state_t               r_state, w_state_nxt;
  logic [DUTY_W-1:0]    r_duty, w_duty_nxt;
  logic [STEP_CW-1:0]   r_step_cnt, w_step_nxt;
  logic [HOLD_CW-1:0]   r_hold_cnt, w_hold_nxt;
  logic                 r_done, w_done_nxt;
  logic                 w_run, w_pend;
  logic                 w_step_hit, w_hold_hit;
  logic [DUTY_W-1:0]    w_duty_up, w_duty_dn;

  assign w_run      = i_en & (r_state != IDLE);
  assign w_step_hit = (r_step_cnt == STEP_CW'(PERIODS_PER_STEP - 1));
  assign w_hold_hit = (r_hold_cnt == HOLD_CW'(HOLD_PERIODS - 1));

  // Saturating ramps compare before adding so nothing can wrap or overshoot.
  assign w_duty_up = (r_duty >= DUTY_W'(PERIOD - STEP)) ? DUTY_W'(PERIOD)
                                                        : r_duty + DUTY_W'(STEP);
  assign w_duty_dn = (r_duty <= DUTY_W'(STEP)) ? '0 : r_duty - DUTY_W'(STEP);

  pwm_gen_core #(
    .PERIOD (PERIOD),
    .DUTY_W (DUTY_W)
  ) u_core (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .run        (w_run),
    .duty       (r_duty),
    .o_pwm      (o_pwm),
    .period_end (w_pend)
  );

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state    <= IDLE;
      r_duty     <= '0;
      r_step_cnt <= '0;
      r_hold_cnt <= '0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_duty     <= w_duty_nxt;
      r_step_cnt <= w_step_nxt;
      r_hold_cnt <= w_hold_nxt;
      r_done     <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_duty_nxt  = r_duty;
    w_step_nxt  = r_step_cnt;
    w_hold_nxt  = r_hold_cnt;
    w_done_nxt  = 1'b0;
    if (!i_en) begin
      w_state_nxt = IDLE;
      w_duty_nxt  = '0;
      w_step_nxt  = '0;
      w_hold_nxt  = '0;
    end else begin
      case (r_state)
        IDLE: w_state_nxt = UP;
        UP: if (w_pend) begin
          if (w_step_hit) begin
            w_step_nxt = '0;
            w_duty_nxt = w_duty_up;
            if (w_duty_up == DUTY_W'(PERIOD)) w_state_nxt = HOLD_HI;
          end else begin
            w_step_nxt = r_step_cnt + 1'b1;
          end
        end
        HOLD_HI: if (w_pend) begin
          if (w_hold_hit) begin
            w_hold_nxt  = '0;
            w_state_nxt = DOWN;
          end else begin
            w_hold_nxt = r_hold_cnt + 1'b1;
          end
        end
        DOWN: if (w_pend) begin
          if (w_step_hit) begin
            w_step_nxt = '0;
            w_duty_nxt = w_duty_dn;
            if (w_duty_dn == '0) w_state_nxt = HOLD_LO;
          end else begin
            w_step_nxt = r_step_cnt + 1'b1;
          end
        end
        HOLD_LO: if (w_pend) begin
          if (w_hold_hit) begin
            w_hold_nxt  = '0;
            w_state_nxt = UP;
            w_done_nxt  = 1'b1;
          end else begin
            w_hold_nxt = r_hold_cnt + 1'b1;
          end
        end
        default: begin
          w_state_nxt = IDLE;
          w_duty_nxt  = '0;
          w_step_nxt  = '0;
          w_hold_nxt  = '0;
        end
      endcase
    end
  end

  assign o_duty        = r_duty;
  assign o_state       = r_state;
  assign o_breath_done = r_done;

endmodule
